// File: rtl/keypad_scan_encoder_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scan encoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2
  } kp_state_e;

  localparam logic [3:0] ROW_RESET   = 4'b1110;
  localparam logic [3:0] COL_IDLE    = 4'hF;
  localparam logic [3:0] KEY_WAIT    = 4'd10;
  localparam logic [3:0] KEY_SETUP   = 4'd11;
  localparam logic [3:0] KEY_READY   = 4'd12;
  localparam logic [3:0] KEY_FIRE    = 4'd13;
  localparam logic [3:0] KEY_SURE    = 4'd14;
  localparam logic [3:0] KEY_CONFIRM = 4'd15;

  // True when exactly one bit is low; ghosting/multi-key patterns fail this.
  function automatic logic one_cold(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  function automatic logic [1:0] zero_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!v[i]) idx = 2'(i);
    return idx;
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/keypad_scan_encoder_key_sync.sv
// Two-flop synchronizer for the asynchronous keypad column inputs (idle high).
module key_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_meta, r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= COL_IDLE;
      r_sync <= COL_IDLE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner/debouncer producing detonator command strobes.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_CNT_MAX = 1000,
  parameter int KEY_CNT_MAX  = 20,
  parameter int REPEAT_DLY   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] A,
  output logic       digit_vld,
  output logic       wait_t,
  output logic       setup,
  output logic       ready,
  output logic       fire,
  output logic       sure,
  output logic       confirm,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_CNT_MAX);
  localparam int KW = $clog2(KEY_CNT_MAX + 1);

  if (SCAN_CNT_MAX < 2 || KEY_CNT_MAX < 1 || REPEAT_DLY < 1) begin : g_bad_param
    $error("keypad_scan_encoder: illegal parameter value");
  end

  logic [3:0]    w_col_s;
  logic [DW-1:0] r_dwell;
  logic          w_sample;
  kp_state_e     r_state, w_nstate;
  logic [3:0]    r_row, w_row_nxt;
  logic [KW-1:0] r_deb, w_deb_nxt, r_rel, w_rel_nxt;
  logic [3:0]    r_pat, r_key, w_key;
  logic          w_latch, w_evt;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY + 1);
  logic [RW-1:0] r_rep, w_rep_nxt;
`endif

  key_sync u_sync (.clk(clk), .rst(rst), .i_d(col_i), .o_q(w_col_s));

  assign w_sample = (r_dwell == DW'(SCAN_CNT_MAX - 1));
  // On a detection sample the key is still unlatched, so derive it live.
  assign w_key = (r_state == SCAN) ? {zero_idx(r_row), zero_idx(w_col_s)} : r_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SCAN;
      r_dwell <= '0;
      r_row   <= ROW_RESET;
      r_deb   <= '0;
      r_rel   <= '0;
      r_pat   <= COL_IDLE;
      r_key   <= '0;
`ifdef KEYPAD_REPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      r_state <= w_nstate;
      r_dwell <= w_sample ? '0 : r_dwell + DW'(1);
      r_row   <= w_row_nxt;
      r_deb   <= w_deb_nxt;
      r_rel   <= w_rel_nxt;
`ifdef KEYPAD_REPEAT_EN
      r_rep   <= w_rep_nxt;
`endif
      if (w_latch) begin
        r_pat <= w_col_s;
        r_key <= w_key;
      end
    end
  end

  always_comb begin
    w_nstate  = r_state;
    w_row_nxt = r_row;
    w_deb_nxt = r_deb;
    w_rel_nxt = r_rel;
    w_latch   = 1'b0;
    w_evt     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_nxt = r_rep;
`endif
    if (w_sample) begin
      case (r_state)
        SCAN: begin
          if (one_cold(w_col_s)) begin
            w_latch = 1'b1;
            if (KEY_CNT_MAX == 1) begin
              w_evt     = 1'b1;
              w_nstate  = HELD;
              w_rel_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
              w_rep_nxt = '0;
`endif
            end else begin
              w_deb_nxt = KW'(1);
              w_nstate  = DEB_PRESS;
            end
          end else begin
            w_row_nxt = rotl(r_row);
          end
        end
        DEB_PRESS: begin
          if (w_col_s == r_pat) begin
            if (r_deb == KW'(KEY_CNT_MAX - 1)) begin
              w_evt     = 1'b1;
              w_nstate  = HELD;
              w_rel_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
              w_rep_nxt = '0;
`endif
            end else begin
              w_deb_nxt = r_deb + KW'(1);
            end
          end else begin
            w_nstate  = SCAN;
            w_row_nxt = rotl(r_row);
          end
        end
        HELD: begin
          if (w_col_s == COL_IDLE) begin
            if (r_rel == KW'(KEY_CNT_MAX - 1)) begin
              w_nstate  = SCAN;
              w_row_nxt = rotl(r_row);
              w_rel_nxt = '0;
            end else begin
              w_rel_nxt = r_rel + KW'(1);
            end
          end else begin
            w_rel_nxt = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (w_col_s == r_pat) begin
            if (r_rep == RW'(REPEAT_DLY - 1)) begin
              w_evt     = 1'b1;
              w_rep_nxt = '0;
            end else begin
              w_rep_nxt = r_rep + RW'(1);
            end
          end else if (w_col_s == COL_IDLE) begin
            w_rep_nxt = '0;
          end
`endif
        end
        default: w_nstate = SCAN;
      endcase
    end
  end

  always_comb begin
    row_o    = r_row;
    key_held = (r_state == HELD);
  end

  // Event strobes are registered so A and the pulses line up on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A         <= '0;
      digit_vld <= 1'b0;
      wait_t    <= 1'b0;
      setup     <= 1'b0;
      ready     <= 1'b0;
      fire      <= 1'b0;
      sure      <= 1'b0;
      confirm   <= 1'b0;
    end else begin
      digit_vld <= 1'b0;
      wait_t    <= 1'b0;
      setup     <= 1'b0;
      ready     <= 1'b0;
      fire      <= 1'b0;
      sure      <= 1'b0;
      confirm   <= 1'b0;
      if (w_evt) begin
        case (w_key)
          KEY_WAIT:    wait_t  <= 1'b1;
          KEY_SETUP:   setup   <= 1'b1;
          KEY_READY:   ready   <= 1'b1;
          KEY_FIRE:    fire    <= 1'b1;
          KEY_SURE:    sure    <= 1'b1;
          KEY_CONFIRM: confirm <= 1'b1;
          default: begin
            A         <= w_key;
            digit_vld <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder with SCAN_CNT_MAX=4, KEY_CNT_MAX=3.
module tb_keypad_scan_encoder;

  localparam int SCAN = 4;
  localparam int KEYC = 3;
`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_K5 = 3;
`else
  localparam int EXP_K5 = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_i;
  logic [3:0] row_o, A;
  logic       digit_vld, wait_t, setup, ready, fire, sure, confirm, key_held;

  logic       kp_on  = 1'b0;
  logic [3:0] kp_row = 4'hF;
  logic [3:0] kp_pat = 4'hF;

  int total = 0, bad = 0, cyc = 0;
  int n_ev = 0, n_dig = 0, n_multi = 0, ev_cyc = 0;
  int n_cmd [6];
  logic [3:0] last_a = 4'h0;
  logic [6:0] mon_p;

  // Keypad model: the pressed key pulls its column low only while its row is driven.
  assign col_i = (kp_on && row_o == kp_row) ? kp_pat : 4'hF;

  always #5 clk = ~clk;

  keypad_scan_encoder #(
    .SCAN_CNT_MAX(SCAN),
    .KEY_CNT_MAX (KEYC),
    .REPEAT_DLY  (2)
  ) dut (
    .clk(clk), .rst(rst), .col_i(col_i), .row_o(row_o), .A(A),
    .digit_vld(digit_vld), .wait_t(wait_t), .setup(setup), .ready(ready),
    .fire(fire), .sure(sure), .confirm(confirm), .key_held(key_held)
  );

  initial for (int i = 0; i < 6; i++) n_cmd[i] = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    mon_p = {confirm, sure, fire, ready, setup, wait_t, digit_vld};
    if ($countones(mon_p) > 1) n_multi = n_multi + 1;
    if (mon_p != 7'd0) begin
      n_ev   = n_ev + 1;
      ev_cyc = cyc;
    end
    if (digit_vld) begin
      n_dig  = n_dig + 1;
      last_a = A;
    end
    for (int i = 1; i < 7; i++) if (mon_p[i]) n_cmd[i-1] = n_cmd[i-1] + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_row(input logic [3:0] r, output int c);
    int n;
    n = 0;
    while (row_o == r && n < 200) begin tick(); n++; end
    while (row_o != r && n < 200) begin tick(); n++; end
    c = cyc;
    total++;
    if (row_o !== r) begin
      bad++;
      $display("FAIL wait_row timeout got=%b exp=%b", row_o, r);
    end
  endtask

  task automatic wait_ev();
    int s;
    int n;
    s = n_ev;
    n = 0;
    while (n_ev == s && n < 200) begin tick(); n++; end
    total++;
    if (n_ev == s) begin
      bad++;
      $display("FAIL wait_event timeout got=none exp=event");
    end
  endtask

  task automatic release_key(input logic [3:0] r);
    int n;
    kp_on = 1'b0;
    n = 0;
    while (row_o == r && n < 60) begin tick(); n++; end
    total++;
    if (row_o === r || key_held !== 1'b0) begin
      bad++;
      $display("FAIL release row=%b held=%b exp_row!=%b held=0", row_o, key_held, r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++;
    if (row_o !== 4'b1110) begin bad++; $display("FAIL rst_row got=%b exp=1110", row_o); end
    total++;
    if (A !== 4'h0) begin bad++; $display("FAIL rst_A got=%h exp=0", A); end
    total++;
    if ({confirm, sure, fire, ready, setup, wait_t, digit_vld, key_held} !== 8'h00) begin
      bad++; $display("FAIL rst_pulses got=%b exp=0", {confirm, sure, fire, ready, setup, wait_t, digit_vld, key_held});
    end
    rst = 1'b0;
    tick(); tick(); tick();
    total++;
    if (row_o !== 4'b1110) begin bad++; $display("FAIL dwell_hold got=%b exp=1110", row_o); end
    tick();
    total++;
    if (row_o !== 4'b1101) begin bad++; $display("FAIL dwell_rotate got=%b exp=1101", row_o); end
  endtask

  task automatic test_key5();
    int c0, d0, p;
    d0 = n_dig;
    kp_row = 4'b1101; kp_pat = 4'b1101;
    wait_row(4'b1110, c0);
    kp_on = 1'b1;
    wait_row(4'b1101, c0);
    wait_ev();
    p = ev_cyc;
    total++;
    if (p - c0 !== 12) begin bad++; $display("FAIL key5_latency got=%0d exp=12", p - c0); end
    total++;
    if (!digit_vld || A !== 4'd5 || key_held !== 1'b1) begin
      bad++; $display("FAIL key5_strobe vld=%b A=%0d held=%b exp 1/5/1", digit_vld, A, key_held);
    end
    repeat (20) tick();
    total++;
    if (n_dig - d0 !== EXP_K5) begin bad++; $display("FAIL key5_count got=%0d exp=%0d", n_dig - d0, EXP_K5); end
    total++;
    if (row_o !== 4'b1101 || A !== 4'd5) begin
      bad++; $display("FAIL key5_frozen row=%b A=%0d exp 1101/5", row_o, A);
    end
    kp_on = 1'b0;
    while (row_o == 4'b1101 && cyc < p + 60) tick();
    total++;
    if (cyc !== p + 32) begin bad++; $display("FAIL key5_release_cycle got=%0d exp=%0d", cyc - p, 32); end
    total++;
    if (row_o !== 4'b1011 || key_held !== 1'b0) begin
      bad++; $display("FAIL key5_release row=%b held=%b exp 1011/0", row_o, key_held);
    end
  endtask

  task automatic test_fire();
    int d0, e0;
    int c0 [6];
    d0 = n_dig; e0 = n_ev;
    for (int i = 0; i < 6; i++) c0[i] = n_cmd[i];
    kp_row = 4'b0111; kp_pat = 4'b1101; kp_on = 1'b1;
    wait_ev();
    release_key(4'b0111);
    total++;
    if (n_cmd[3] - c0[3] !== 1) begin bad++; $display("FAIL fire_count got=%0d exp=1", n_cmd[3] - c0[3]); end
    total++;
    if (n_ev - e0 !== 1 || n_dig !== d0) begin
      bad++; $display("FAIL fire_others events=%0d digits=%0d exp 1/0", n_ev - e0, n_dig - d0);
    end
    total++;
    if (A !== 4'd5) begin bad++; $display("FAIL fire_A_held got=%0d exp=5", A); end
  endtask

  task automatic test_bounce();
    int c0, d0;
    d0 = n_dig;
    kp_row = 4'b1110; kp_pat = 4'b1011;
    wait_row(4'b1110, c0);
    kp_on = 1'b1;
    repeat (4) tick();
    kp_on = 1'b0;
    repeat (4) tick();
    total++;
    if (row_o !== 4'b1101 || n_dig !== d0) begin
      bad++; $display("FAIL bounce_abort row=%b digits=%0d exp 1101/0", row_o, n_dig - d0);
    end
    kp_on = 1'b1;
    wait_row(4'b1110, c0);
    wait_ev();
    total++;
    if (ev_cyc - c0 !== 12) begin bad++; $display("FAIL bounce_latency got=%0d exp=12", ev_cyc - c0); end
    release_key(4'b1110);
    total++;
    if (n_dig - d0 !== 1 || last_a !== 4'd2) begin
      bad++; $display("FAIL bounce_digit count=%0d A=%0d exp 1/2", n_dig - d0, last_a);
    end
  endtask

  task automatic test_ghost();
    int c0, e0;
    e0 = n_ev;
    kp_row = 4'b1110; kp_pat = 4'b1100;
    wait_row(4'b1110, c0);
    kp_on = 1'b1;
    repeat (4) tick();
    total++;
    if (row_o !== 4'b1101) begin bad++; $display("FAIL ghost_rotate got=%b exp=1101", row_o); end
    repeat (40) tick();
    total++;
    if (n_ev !== e0 || key_held !== 1'b0) begin
      bad++; $display("FAIL ghost_event events=%0d held=%b exp 0/0", n_ev - e0, key_held);
    end
    kp_on = 1'b0;
  endtask

  task automatic test_reset_held();
    int cf, e0;
    kp_row = 4'b0111; kp_pat = 4'b0111; kp_on = 1'b1;
    cf = n_cmd[5];
    wait_ev();
    total++;
    if (n_cmd[5] - cf !== 1) begin bad++; $display("FAIL confirm_count got=%0d exp=1", n_cmd[5] - cf); end
    repeat (6) tick();
    total++;
    if (key_held !== 1'b1) begin bad++; $display("FAIL confirm_held got=%b exp=1", key_held); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (row_o !== 4'b1110 || A !== 4'h0 || key_held !== 1'b0) begin
      bad++; $display("FAIL async_rst row=%b A=%0d held=%b exp 1110/0/0", row_o, A, key_held);
    end
    total++;
    if ({confirm, sure, fire, ready, setup, wait_t, digit_vld} !== 7'd0) begin
      bad++; $display("FAIL async_rst_pulses got=%b exp=0", {confirm, sure, fire, ready, setup, wait_t, digit_vld});
    end
    kp_on = 1'b0;
    tick();
    rst = 1'b0;
    e0 = n_ev;
    repeat (100) tick();
    total++;
    if (n_ev !== e0) begin bad++; $display("FAIL post_rst_event got=%0d exp=0", n_ev - e0); end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int d0;
    d0 = n_dig;
    kp_row = 4'b1101; kp_pat = 4'b0111; kp_on = 1'b1;
    wait_ev();
    repeat (39) tick();
    release_key(4'b1101);
    total++;
    if (n_dig - d0 !== 6 || last_a !== 4'd7) begin
      bad++; $display("FAIL repeat_count count=%0d A=%0d exp 6/7", n_dig - d0, last_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_key5();
    test_fire();
    test_bounce();
    test_ghost();
    test_reset_held();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    total++;
    if (n_multi !== 0) begin bad++; $display("FAIL pulse_exclusive got=%0d exp=0", n_multi); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
